// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush/bubble control with load, multicycle and branch hazards
module hazard_control_unit #(
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_taken,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              mem_read_ex,
  input  logic              mc_start,
  input  logic              mc_done,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_hold,
  output logic              control_sel,
  output logic              ex_mem_bubble,
  output logic              flush_if_id,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {IDLE, MC_BUSY, FLUSH} state_t;

  state_t     state, state_nxt;
  logic [1:0] flush_cnt, flush_cnt_nxt;
  logic       pend_hz;
  logic       load_hz;

  // Register r is a hazard for the ID instruction only if it is really read and is not x0.
  function automatic logic src_match(input logic used, input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] r);
    return used && (rs == r) && (r != '0);
  endfunction

  // Loads that left EX recently but whose data is still not forwardable to ID.
  generate
    if (LOAD_LAT > 1) begin : g_pend
      localparam int PD = LOAD_LAT - 1;
      logic [PD-1:0]     pend_v;
      logic [REG_AW-1:0] pend_a [PD];

      // Unconditional shift; a load issued while the multicycle unit is busy is frozen, not advancing.
      always_ff @(posedge clk) begin
        if (reset) begin
          pend_v <= '0;
          for (int k = 0; k < PD; k++) pend_a[k] <= '0;
        end else begin
          pend_v[0] <= mem_read_ex && (rd_ex != '0) && (state != MC_BUSY);
          pend_a[0] <= rd_ex;
          for (int k = 1; k < PD; k++) begin
            pend_v[k] <= pend_v[k-1];
            pend_a[k] <= pend_a[k-1];
          end
        end
      end

      // Any in-flight load whose destination the ID instruction reads.
      always_comb begin
        pend_hz = 1'b0;
        for (int k = 0; k < PD; k++) begin
          if (pend_v[k] && (src_match(rs1_used, rs1_id, pend_a[k]) ||
                            src_match(rs2_used, rs2_id, pend_a[k])))
            pend_hz = 1'b1;
        end
      end
    end else begin : g_nopend
      assign pend_hz = 1'b0;
    end
  endgenerate

  assign load_hz = (mem_read_ex && (src_match(rs1_used, rs1_id, rd_ex) ||
                                    src_match(rs2_used, rs2_id, rd_ex))) || pend_hz;

  // State and flush-length register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next state and outputs, highest-priority hazard first.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_hold    = 1'b0;
    control_sel   = 1'b0;
    ex_mem_bubble = 1'b0;
    flush_if_id   = 1'b0;
    if (reset) begin
      state_nxt     = IDLE;
      flush_cnt_nxt = '0;
    end else if (state == MC_BUSY || (mc_start && !branch_taken)) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_hold    = 1'b1;
      ex_mem_bubble = 1'b1;
      flush_cnt_nxt = '0;
      state_nxt     = mc_done ? IDLE : MC_BUSY;
    end else if (branch_taken) begin
      control_sel = 1'b1;
      flush_if_id = 1'b1;
      if (FLUSH_DEPTH > 1) begin
        state_nxt     = FLUSH;
        flush_cnt_nxt = 2'(FLUSH_DEPTH - 1);
      end else begin
        state_nxt     = IDLE;
        flush_cnt_nxt = '0;
      end
    end else if (state == FLUSH) begin
      control_sel   = 1'b1;
      flush_if_id   = 1'b1;
      flush_cnt_nxt = flush_cnt - 2'd1;
      if (flush_cnt <= 2'd1) state_nxt = IDLE;
    end else if (load_hz) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      control_sel = 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (stall_count != {CNT_W{1'b1}})) stall_count <= stall_count + CNT_W'(1);
      if (flush_if_id && (flush_count != {CNT_W{1'b1}})) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
